// File: rtl/dual_bank_mem_responder.sv
// dual_bank_mem_responder: two-bank memory responder with fixed access latency and one-cycle served pulse
// Ports:
//   clk, rst (async, active-low)
//   req_valid, address_in, data_in, mem_enable0/1, read_en0/1, write_en0/1 : controller dispatch
//   served : completion pulse (pops controller FIFO)
//   rdata/rvalid : registered read data and its strobe
//   resp_err : completion of an illegal request (no array access)
//   busy : FSM not idle
module dual_bank_mem_responder #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  mem_enable0,
    input  logic                  mem_enable1,
    input  logic                  read_en0,
    input  logic                  write_en0,
    input  logic                  read_en1,
    input  logic                  write_en1,
    output logic                  served,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  resp_err,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  bank_q, bank_d, wr_q, wr_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q;
    logic                  served_q, rvalid_q, resp_err_q, busy_q;
    logic [DATA_WIDTH-1:0] bank0_mem [DEPTH];
    logic [DATA_WIDTH-1:0] bank1_mem [DEPTH];
    logic                  req0, req1, done, legal_rd;
    assign req0     = req_valid & mem_enable0 & (read_en0 | write_en0);
    assign req1     = req_valid & mem_enable1 & (read_en1 | write_en1);
    assign done     = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign legal_rd = done & ~err_q & ~wr_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                state_d = ACCESS;
                cnt_d   = 4'(LATENCY - 1);
                bank_d  = ~req0;
                wr_d    = req0 ? write_en0 : write_en1;
                // both banks at once, or read+write on the chosen bank, is completed as an error
                err_d   = (req0 & req1) | (req0 ? (read_en0 & write_en0) : (read_en1 & write_en1));
                addr_d  = address_in;
                data_d  = data_in;
            end
            ACCESS: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? RESP : ACCESS;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bank_q     <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            served_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            resp_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bank_q     <= bank_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= legal_rd ? (bank_q ? bank1_mem[addr_q] : bank0_mem[addr_q]) : rdata_q;
            served_q   <= done;
            rvalid_q   <= legal_rd;
            resp_err_q <= done & err_q;
            busy_q     <= state_d != IDLE;
        end
    end
    // arrays carry no reset; a reset forces IDLE so an in-flight write is dropped
    always_ff @(posedge clk) begin
        if (done & ~err_q & wr_q) begin
            if (bank_q) bank1_mem[addr_q] <= data_q;
            else        bank0_mem[addr_q] <= data_q;
        end
    end
    assign served   = served_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign resp_err = resp_err_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_dual_bank_mem_responder.sv
// tb_dual_bank_mem_responder: randomized and directed bench against a schedule-based reference model
module tb_dual_bank_mem_responder;
    localparam int DW = 256;
    localparam int AW = 5;
    localparam int L  = 2;
    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [AW-1:0] address_in;
    logic [DW-1:0] data_in;
    logic          mem_enable0, mem_enable1, read_en0, write_en0, read_en1, write_en1;
    logic          served, rvalid, resp_err, busy;
    logic [DW-1:0] rdata;
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    dual_bank_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .address_in(address_in), .data_in(data_in),
        .mem_enable0(mem_enable0), .mem_enable1(mem_enable1), .read_en0(read_en0), .write_en0(write_en0),
        .read_en1(read_en1), .write_en1(write_en1), .served(served), .rdata(rdata), .rvalid(rvalid),
        .resp_err(resp_err), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    function automatic logic [DW-1:0] init_val(input int b, input int a);
        logic [7:0] x;
        x = 8'(b * 32 + a + 1);
        return {32{x}};
    endfunction
    // reference model: each accepted request completes LATENCY edges after sampling,
    // and the next sample can happen no earlier than two edges after completion
    logic [DW-1:0] mm [2][32];
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_s = 0, exp_rv = 0, exp_er = 0, exp_busy = 0;
    int            done_cyc = -1, idle_from = 0, p_bank = 0;
    logic          p_wr = 0, p_err = 0, q0, q1;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            done_cyc = -1;
            idle_from = cyc + 1;
            exp_s = 0; exp_rv = 0; exp_er = 0; exp_busy = 0;
            exp_rdata = '0;
        end else begin
            exp_s = 0; exp_rv = 0; exp_er = 0;
            if (cyc == done_cyc) begin
                exp_s = 1;
                if (p_err) exp_er = 1;
                else if (p_wr) mm[p_bank][p_addr] = p_data;
                else begin
                    exp_rdata = mm[p_bank][p_addr];
                    exp_rv = 1;
                end
            end
            if (cyc >= idle_from) begin
                q0 = req_valid & mem_enable0 & (read_en0 | write_en0);
                q1 = req_valid & mem_enable1 & (read_en1 | write_en1);
                if (q0 | q1) begin
                    p_bank = q0 ? 0 : 1;
                    p_wr   = q0 ? write_en0 : write_en1;
                    p_err  = (q0 & q1) | (q0 ? (read_en0 & write_en0) : (read_en1 & write_en1));
                    p_addr = address_in;
                    p_data = data_in;
                    done_cyc  = cyc + L;
                    idle_from = cyc + L + 2;
                end
            end
            exp_busy = cyc <= done_cyc;
        end
    end
    always @(posedge clk) begin
        #2;
        chk("served", served, exp_s);
        chk("rvalid", rvalid, exp_rv);
        chk("resp_err", resp_err, exp_er);
        chk("busy", busy, exp_busy);
        chk("rdata", rdata, exp_rdata);
    end
    task automatic set_idle();
        req_valid = 0; mem_enable0 = 0; mem_enable1 = 0;
        read_en0 = 0; write_en0 = 0; read_en1 = 0; write_en1 = 0;
        address_in = '0; data_in = '0;
    endtask
    task automatic set_req(input logic bk, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_idle();
        req_valid = 1;
        mem_enable0 = ~bk; mem_enable1 = bk;
        read_en0 = ~bk & rd; write_en0 = ~bk & wr;
        read_en1 = bk & rd;  write_en1 = bk & wr;
        address_in = a; data_in = d;
    endtask
    task automatic wait_served(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (served) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_served timeout got=none exp=pulse");
    endtask
    int n, cnt;
    int s [4];
    logic [DW-1:0] x0, x1;
    initial begin
        rst = 0;
        set_idle();
        repeat (3) @(negedge clk);
        chk("reset_served", served, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rdata", rdata, 0);
        rst = 1;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 32; a++) begin
                set_req(b[0], 0, 1, AW'(a), init_val(b, a));
                wait_served(n);
            end
        set_idle();
        repeat (3) @(negedge clk);
        set_req(0, 0, 1, 5, {32{8'hA5}});
        wait_served(n);
        chk("wr_latency", n, L + 1);
        chk("wr_rvalid", rvalid, 0);
        set_req(0, 1, 0, 5, '0);
        wait_served(n);
        chk("rd_rvalid", rvalid, 1);
        chk("rd_data", rdata, {32{8'hA5}});
        set_req(1, 0, 1, 5, 256'h1);
        wait_served(n);
        set_req(0, 1, 0, 5, '0);
        wait_served(n);
        chk("iso_rvalid", rvalid, 1);
        chk("iso_data", rdata, {32{8'hA5}});
        set_idle();
        req_valid = 1; mem_enable1 = 1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (served || busy) cnt++;
        end
        chk("idle_default", cnt, 0);
        set_req(0, 1, 1, 7, {8{32'hDEADBEEF}});
        wait_served(n);
        chk("ill_err", resp_err, 1);
        chk("ill_rvalid", rvalid, 0);
        chk("ill_rdata", rdata, {32{8'hA5}});
        set_req(0, 1, 0, 7, '0);
        wait_served(n);
        chk("ill_readback", rdata, init_val(0, 7));
        set_idle();
        repeat (3) @(negedge clk);
        set_req(1, 0, 1, 3, {8{32'hCAFEF00D}});
        @(negedge clk);
        rst = 0;
        set_idle();
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (served) cnt++;
            chk("rst_busy", busy, 0);
            chk("rst_rdata", rdata, 0);
        end
        rst = 1;
        repeat (3) begin
            @(negedge clk);
            if (served) cnt++;
        end
        chk("rst_no_served", cnt, 0);
        set_req(1, 1, 0, 3, '0);
        wait_served(n);
        chk("rst_readback", rdata, init_val(1, 3));
        set_idle();
        repeat (3) @(negedge clk);
        x0 = {8{$urandom}};
        x1 = {8{$urandom}};
        set_req(0, 0, 1, 9, x0); wait_served(n); s[0] = cyc;
        set_req(0, 1, 0, 9, '0); wait_served(n); s[1] = cyc;
        chk("stream_rd0", rdata, x0);
        set_req(1, 0, 1, 9, x1); wait_served(n); s[2] = cyc;
        set_req(1, 1, 0, 9, '0); wait_served(n); s[3] = cyc;
        chk("stream_rd1", rdata, x1);
        set_idle();
        for (int i = 1; i < 4; i++) chk("stream_gap", s[i] - s[i-1], L + 2);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (served) cnt++;
        end
        chk("stream_no_extra", cnt, 0);
        repeat (800) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) != 0);
            req_valid = 1'($urandom_range(0, 1));
            mem_enable0 = 1'($urandom_range(0, 1));
            mem_enable1 = 1'($urandom_range(0, 1));
            read_en0 = 1'($urandom_range(0, 1));
            write_en0 = 1'($urandom_range(0, 1));
            read_en1 = 1'($urandom_range(0, 1));
            write_en1 = 1'($urandom_range(0, 1));
            address_in = AW'($urandom);
            data_in = {8{$urandom}};
        end
        @(negedge clk);
        rst = 1;
        set_idle();
        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
